// File: rtl/rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ctrl
//  Description : Reorder-buffer controller. Allocates entries in order,
//                accepts out-of-order completions, retires in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_ctrl #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            alloc_valid,
    input  logic [31:0]     alloc_instr,
    output logic            alloc_ready,
    output logic [TAGW-1:0] alloc_tag,
    input  logic            cmpl_valid,
    input  logic [TAGW-1:0] cmpl_tag,
    input  logic [31:0]     cmpl_val,
    output logic            commit_valid,
    input  logic            commit_ready,
    output logic [31:0]     commit_instr,
    output logic [31:0]     commit_val,
    output logic [TAGW:0]   count,
    output logic            empty,
    output logic            full
);

    localparam logic [TAGW:0]   c_depth  = (TAGW+1)'(DEPTH);
    localparam logic [TAGW-1:0] c_tag_one = TAGW'(1);

    logic            r_valid [DEPTH];
    logic            r_ready [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic [31:0]     r_val   [DEPTH];
    logic [TAGW-1:0] r_head;
    logic [TAGW-1:0] r_tail;
    logic [TAGW:0]   r_count;

    logic w_full;
    logic w_head_valid;
    logic w_accept;
    logic w_retire;
    logic w_cmpl;

    assign w_full       = (r_count == c_depth);
    assign w_head_valid = r_valid[r_head];

    // Capacity decision uses registered state only; a same-cycle retire does
    // not open a slot for a same-cycle accept.
    assign w_accept = alloc_valid & ~w_full & ~flush;
    assign w_retire = commit_valid & commit_ready;

    // A completion racing the allocation of its own tag is dropped.
    assign w_cmpl = cmpl_valid & ~flush
                  & r_valid[cmpl_tag] & ~r_ready[cmpl_tag]
                  & ~(w_accept & (cmpl_tag == r_tail));

    assign alloc_ready  = ~w_full;
    assign alloc_tag    = r_tail;
    assign commit_valid = w_head_valid & r_ready[r_head] & ~flush;
    assign commit_instr = w_head_valid ? r_instr[r_head] : 32'd0;
    assign commit_val   = w_head_valid ? r_val[r_head]   : 32'd0;
    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign full         = w_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
                r_instr[i] <= 32'd0;
                r_val[i]   <= 32'd0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ready[i] <= 1'b0;
                r_instr[i] <= 32'd0;
                r_val[i]   <= 32'd0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Head and tail only coincide when empty or full, so retire and
            // accept never touch the same entry.
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_instr[r_head] <= 32'd0;
                r_val[r_head]   <= 32'd0;
                r_head          <= r_head + c_tag_one;
            end
            if (w_cmpl) begin
                r_ready[cmpl_tag] <= 1'b1;
                r_val[cmpl_tag]   <= cmpl_val;
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_instr[r_tail] <= alloc_instr;
                r_val[r_tail]   <= 32'd0;
                r_tail          <= r_tail + c_tag_one;
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_ctrl
//  Description : Directed self-checking bench for rob_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rob_ctrl;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        alloc_valid;
    logic [31:0] alloc_instr;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cmpl_valid;
    logic [2:0]  cmpl_tag;
    logic [31:0] cmpl_val;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_instr;
    logic [31:0] commit_val;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    rob_ctrl #(.DEPTH(8), .TAGW(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_instr  (alloc_instr),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cmpl_valid   (cmpl_valid),
        .cmpl_tag     (cmpl_tag),
        .cmpl_val     (cmpl_val),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_instr (commit_instr),
        .commit_val   (commit_val),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] instr);
        alloc_valid = 1'b1;
        alloc_instr = instr;
        cyc();
        alloc_valid = 1'b0;
        alloc_instr = 32'd0;
    endtask

    task automatic do_cmpl(input logic [2:0] tag, input logic [31:0] val);
        cmpl_valid = 1'b1;
        cmpl_tag   = tag;
        cmpl_val   = val;
        cyc();
        cmpl_valid = 1'b0;
        cmpl_tag   = 3'd0;
        cmpl_val   = 32'd0;
    endtask

    task automatic test_reset();
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%b exp=1", alloc_ready); end
        total++; if (alloc_tag !== 3'd0) begin bad++; $display("FAIL rst_alloc_tag got=%0d exp=0", alloc_tag); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_commit_valid got=%b exp=0", commit_valid); end
        total++; if ({commit_instr, commit_val} !== 64'd0) begin bad++; $display("FAIL rst_commit_data got=%h/%h exp=0/0", commit_instr, commit_val); end
        total++; if ({count, empty, full} !== {4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL rst_status got=cnt%0d e%b f%b exp=cnt0 e1 f0", count, empty, full); end
    endtask

    task automatic test_out_of_order();
        logic [31:0] exp_i [3];
        logic [31:0] exp_v [3];
        exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33;
        exp_v[0] = 32'hA;  exp_v[1] = 32'hB;  exp_v[2] = 32'hC;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            total++; if (alloc_tag !== 3'(i)) begin bad++; $display("FAIL ooo_tag got=%0d exp=%0d", alloc_tag, i); end
            do_alloc(exp_i[i]);
        end
        total++; if (count !== 4'd3) begin bad++; $display("FAIL ooo_count got=%0d exp=3", count); end
        do_cmpl(3'd2, 32'hC);
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_head_not_ready got=%b exp=0", commit_valid); end
        do_cmpl(3'd0, 32'hA);
        do_cmpl(3'd1, 32'hB);
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (commit_valid !== 1'b1 || commit_instr !== exp_i[i] || commit_val !== exp_v[i]) begin
                bad++;
                $display("FAIL ooo_retire%0d got=v%b %h/%h exp=v1 %h/%h", i, commit_valid, commit_instr, commit_val, exp_i[i], exp_v[i]);
            end
            cyc();
        end
        commit_ready = 1'b0;
        total++; if (commit_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL ooo_drained got=v%b e%b exp=v0 e1", commit_valid, empty); end
    endtask

    task automatic test_full_wrap();
        pulse_reset();
        for (int i = 0; i < 8; i++) do_alloc(32'h100 + 32'(i));
        total++; if ({full, alloc_ready, count} !== {1'b1, 1'b0, 4'd8}) begin bad++; $display("FAIL full_state got=f%b r%b cnt%0d exp=f1 r0 cnt8", full, alloc_ready, count); end
        do_alloc(32'hDEAD);
        total++; if (count !== 4'd8 || alloc_tag !== 3'd0) begin bad++; $display("FAIL full_ninth got=cnt%0d tag%0d exp=cnt8 tag0", count, alloc_tag); end
        do_cmpl(3'd0, 32'h55);
        total++; if (commit_instr !== 32'h100 || commit_val !== 32'h55) begin bad++; $display("FAIL full_head got=%h/%h exp=100/55", commit_instr, commit_val); end
        // Full: a same-cycle alloc is refused, only the retire takes effect.
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_instr  = 32'hBAD;
        cyc();
        commit_ready = 1'b0;
        alloc_valid  = 1'b0;
        total++; if (count !== 4'd7 || alloc_tag !== 3'd0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_retire got=cnt%0d tag%0d r%b exp=cnt7 tag0 r1", count, alloc_tag, alloc_ready); end
        do_alloc(32'h200);
        total++; if (count !== 4'd8 || alloc_tag !== 3'd1) begin bad++; $display("FAIL wrap_alloc got=cnt%0d tag%0d exp=cnt8 tag1", count, alloc_tag); end
        do_cmpl(3'd1, 32'h66);
        commit_ready = 1'b1;
        cyc();
        commit_ready = 1'b0;
        do_cmpl(3'd2, 32'h77);
        total++; if (commit_instr !== 32'h102 || commit_val !== 32'h77) begin bad++; $display("FAIL wrap_head got=%h/%h exp=102/77", commit_instr, commit_val); end
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_instr  = 32'h300;
        cyc();
        commit_ready = 1'b0;
        alloc_valid  = 1'b0;
        total++; if (count !== 4'd7 || alloc_tag !== 3'd2) begin bad++; $display("FAIL both_same_cycle got=cnt%0d tag%0d exp=cnt7 tag2", count, alloc_tag); end
    endtask

    task automatic test_spurious_cmpl();
        pulse_reset();
        do_cmpl(3'd3, 32'h77);
        total++; if ({commit_valid, count, empty} !== {1'b0, 4'd0, 1'b1}) begin bad++; $display("FAIL cmpl_empty got=v%b cnt%0d e%b exp=v0 cnt0 e1", commit_valid, count, empty); end
        do_alloc(32'h44);
        do_cmpl(3'd0, 32'h5);
        do_cmpl(3'd0, 32'h6);
        total++; if (commit_valid !== 1'b1 || commit_val !== 32'h5) begin bad++; $display("FAIL cmpl_twice got=v%b %h exp=v1 5", commit_valid, commit_val); end
        // Completion aimed at the tag being allocated this cycle.
        alloc_valid = 1'b1;
        alloc_instr = 32'h66;
        cmpl_valid  = 1'b1;
        cmpl_tag    = 3'd1;
        cmpl_val    = 32'h9;
        cyc();
        alloc_valid = 1'b0;
        cmpl_valid  = 1'b0;
        commit_ready = 1'b1;
        cyc();
        commit_ready = 1'b0;
        total++; if (commit_valid !== 1'b0 || commit_instr !== 32'h66) begin bad++; $display("FAIL cmpl_on_alloc got=v%b %h exp=v0 66", commit_valid, commit_instr); end
        do_cmpl(3'd1, 32'hE);
        total++; if (commit_valid !== 1'b1 || commit_val !== 32'hE) begin bad++; $display("FAIL cmpl_after got=v%b %h exp=v1 e", commit_valid, commit_val); end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        for (int i = 0; i < 4; i++) do_alloc(32'hA0 + 32'(i));
        do_cmpl(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (commit_valid !== 1'b1 || commit_instr !== 32'hA0 || commit_val !== 32'h1 || count !== 4'd4) begin
                bad++;
                $display("FAIL hold%0d got=v%b %h/%h cnt%0d exp=v1 a0/1 cnt4", i, commit_valid, commit_instr, commit_val, count);
            end
            cyc();
        end
        commit_ready = 1'b1;
        cyc();
        commit_ready = 1'b0;
        total++; if (count !== 4'd3 || commit_valid !== 1'b0 || commit_instr !== 32'hA1) begin bad++; $display("FAIL hold_release got=cnt%0d v%b %h exp=cnt3 v0 a1", count, commit_valid, commit_instr); end
    endtask

    task automatic test_flush();
        pulse_reset();
        for (int i = 0; i < 5; i++) do_alloc(32'hF0 + 32'(i));
        do_cmpl(3'd0, 32'h3);
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        alloc_instr  = 32'h99;
        cmpl_valid   = 1'b1;
        cmpl_tag     = 3'd1;
        cmpl_val     = 32'h4;
        commit_ready = 1'b1;
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_masks_commit got=%b exp=0", commit_valid); end
        cyc();
        flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0; commit_ready = 1'b0;
        total++; if ({count, empty, alloc_tag, commit_valid} !== {4'd0, 1'b1, 3'd0, 1'b0}) begin bad++; $display("FAIL flush_state got=cnt%0d e%b tag%0d v%b exp=cnt0 e1 tag0 v0", count, empty, alloc_tag, commit_valid); end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int i = 0; i < 6; i++) do_alloc(32'hC0 + 32'(i));
        do_cmpl(3'd0, 32'h8);
        #2;
        reset_n      = 1'b0;
        commit_ready = 1'b1;
        #1;
        total++;
        if ({alloc_ready, alloc_tag, commit_valid, count, empty, full} !== {1'b1, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0} || commit_instr !== 32'd0 || commit_val !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got=r%b tag%0d v%b cnt%0d e%b f%b %h/%h", alloc_ready, alloc_tag, commit_valid, count, empty, full, commit_instr, commit_val);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        commit_ready = 1'b0;
        total++; if (count !== 4'd0 || alloc_tag !== 3'd0) begin bad++; $display("FAIL async_release got=cnt%0d tag%0d exp=cnt0 tag0", count, alloc_tag); end
        do_alloc(32'hBEEF);
        total++; if (count !== 4'd1 || alloc_tag !== 3'd1 || commit_instr !== 32'hBEEF) begin bad++; $display("FAIL async_first_alloc got=cnt%0d tag%0d %h exp=cnt1 tag1 beef", count, alloc_tag, commit_instr); end
    endtask

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_instr  = 32'd0;
        cmpl_valid   = 1'b0;
        cmpl_tag     = 3'd0;
        cmpl_val     = 32'd0;
        commit_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        test_out_of_order();
        test_full_wrap();
        test_spurious_cmpl();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
